// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with load-use stall detection and
//          same-cycle operand forwarding from the EX/MEM and MEM/WB stages.
// Rev    : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic [W-1:0] id_rs_data,
    input  logic [W-1:0] id_rt_data,
    input  logic [W-1:0] id_imm,
    input  logic         id_rt_used,
    input  logic [3:0]   id_alu_ctr,
    input  logic         id_alu_src,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         flush,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [3:0]   ALU_ctr,
    output logic [W-1:0] data1,
    output logic [W-1:0] data2,
    output logic [W-1:0] ex_store_data,
    output logic         ex_valid,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic [4:0]   ex_rd,
    output logic         stall
);

    localparam logic [3:0] C_ALU_NOP = 4'd15;

    logic         r_valid;
    logic [4:0]   r_rs;
    logic [4:0]   r_rt;
    logic [4:0]   r_rd;
    logic [W-1:0] r_rs_data;
    logic [W-1:0] r_rt_data;
    logic [W-1:0] r_imm;
    logic [3:0]   r_alu_ctr;
    logic         r_alu_src;
    logic         r_reg_write;
    logic         r_mem_read;
    logic         r_mem_write;

    logic         w_hazard;
    logic         w_capture;
    logic [W-1:0] w_fwd_a;
    logic [W-1:0] w_fwd_b;

    // Load in EX whose destination is read by the instruction in ID.
    assign w_hazard = id_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                      ((r_rd == id_rs) || (id_rt_used && (r_rd == id_rt)));
    assign w_capture = !flush && !w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs        <= 5'd0;
            r_rt        <= 5'd0;
            r_rd        <= 5'd0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_ctr   <= C_ALU_NOP;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= id_valid;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_ctr   <= id_alu_ctr;
            r_alu_src   <= id_alu_src;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end else begin
            // Bubble: register numbers cleared so nothing forwards into it.
            r_valid     <= 1'b0;
            r_rs        <= 5'd0;
            r_rt        <= 5'd0;
            r_rd        <= 5'd0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_ctr   <= C_ALU_NOP;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        w_fwd_a = r_rs_data;
        if (exmem_reg_write && (exmem_rd == r_rs) && (r_rs != 5'd0)) begin
            w_fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == r_rs) && (r_rs != 5'd0)) begin
            w_fwd_a = memwb_result;
        end
    end

    always_comb begin
        w_fwd_b = r_rt_data;
        if (exmem_reg_write && (exmem_rd == r_rt) && (r_rt != 5'd0)) begin
            w_fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd == r_rt) && (r_rt != 5'd0)) begin
            w_fwd_b = memwb_result;
        end
    end

    assign data1         = w_fwd_a;
    assign data2         = r_alu_src ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;

    // A captured but invalid slot must look exactly like a bubble downstream.
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_valid && r_reg_write;
    assign ex_mem_read   = r_valid && r_mem_read;
    assign ex_mem_write  = r_valid && r_mem_write;
    assign ALU_ctr       = r_valid ? r_alu_ctr : C_ALU_NOP;
    assign ex_rd         = r_rd;
    assign stall         = w_hazard && !flush;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// Testbench for id_ex_stage: directed scenarios plus random traffic, checked
// by a scoreboard fed from a behavioural model of the EX stage.
module tb_id_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         id_valid, id_rt_used, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]   id_rs, id_rt, id_rd;
    logic [W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]   id_alu_ctr;
    logic         flush, exmem_reg_write, memwb_reg_write;
    logic [4:0]   exmem_rd, memwb_rd;
    logic [W-1:0] exmem_result, memwb_result;
    logic [3:0]   ALU_ctr;
    logic [W-1:0] data1, data2, ex_store_data;
    logic         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
    logic [4:0]   ex_rd;

    id_ex_stage #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rt_used(id_rt_used), .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ALU_ctr(ALU_ctr), .data1(data1), .data2(data2), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid, rt_used, alu_src, rw, mr, mw;
        logic [4:0]   rs, rt, rd;
        logic [W-1:0] rs_data, rt_data, imm;
        logic [3:0]   alu_ctr;
        logic         flush, xw, ww;
        logic [4:0]   xrd, wrd;
        logic [W-1:0] xres, wres;
    } in_t;

    // known=0 means the slot is a bubble whose stored operands are don't-care.
    typedef struct {
        bit  known;
        bit  live;
        in_t ins;
    } ex_t;

    typedef struct {
        bit           chk;
        logic         valid, rw, mr, mw, stall;
        logic [4:0]   rd;
        logic [3:0]   alu;
        logic [W-1:0] d1, d2, sd;
    } exp_t;

    exp_t q[$];
    ex_t  m;
    in_t  cur;
    bit   last_stall;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t nop();
        in_t n;
        n.valid = 0; n.rt_used = 0; n.alu_src = 0; n.rw = 0; n.mr = 0; n.mw = 0;
        n.rs = 0; n.rt = 0; n.rd = 0; n.rs_data = 0; n.rt_data = 0; n.imm = 0;
        n.alu_ctr = 0; n.flush = 0; n.xw = 0; n.ww = 0; n.xrd = 0; n.wrd = 0;
        n.xres = 0; n.wres = 0;
        return n;
    endfunction

    function automatic ex_t reset_state();
        ex_t e;
        e.known = 1; e.live = 0; e.ins = nop();
        return e;
    endfunction

    // Value of register r as seen in EX: youngest in-flight producer wins, r0 never forwarded.
    function automatic logic [W-1:0] fwd(input logic [4:0] r, input logic [W-1:0] rf, input in_t c);
        if (r == 0) return rf;
        if (c.xw && c.xrd == r) return c.xres;
        if (c.ww && c.wrd == r) return c.wres;
        return rf;
    endfunction

    function automatic exp_t expect_out(input ex_t s, input in_t c);
        exp_t e;
        e.chk   = s.known;
        e.valid = s.live;
        e.rw    = s.live & s.ins.rw;
        e.mr    = s.live & s.ins.mr;
        e.mw    = s.live & s.ins.mw;
        e.alu   = s.live ? s.ins.alu_ctr : 4'd15;
        e.rd    = s.ins.rd;
        e.d1    = fwd(s.ins.rs, s.ins.rs_data, c);
        e.sd    = fwd(s.ins.rt, s.ins.rt_data, c);
        e.d2    = s.ins.alu_src ? s.ins.imm : e.sd;
        e.stall = !c.flush && c.valid && e.mr && (s.ins.rd != 0) &&
                  ((s.ins.rd == c.rs) || (c.rt_used && s.ins.rd == c.rt));
        return e;
    endfunction

    task automatic drive(input in_t c);
        id_valid = c.valid; id_rt_used = c.rt_used; id_alu_src = c.alu_src;
        id_reg_write = c.rw; id_mem_read = c.mr; id_mem_write = c.mw;
        id_rs = c.rs; id_rt = c.rt; id_rd = c.rd;
        id_rs_data = c.rs_data; id_rt_data = c.rt_data; id_imm = c.imm;
        id_alu_ctr = c.alu_ctr; flush = c.flush;
        exmem_reg_write = c.xw; exmem_rd = c.xrd; exmem_result = c.xres;
        memwb_reg_write = c.ww; memwb_rd = c.wrd; memwb_result = c.wres;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e = expect_out(m, cur);
        last_stall = e.stall;
        q.push_back(e);
    endtask

    // One clock: advance the model across the edge, then present the next inputs.
    task automatic cyc(input in_t nx);
        @(posedge clk);
        if (!rst_n) m = reset_state();
        else if (cur.flush || last_stall) begin
            m.known = 0; m.live = 0;
        end else begin
            m.known = 1; m.live = cur.valid; m.ins = cur;
        end
        #1;
        cur = nx;
        drive(cur);
        push_expect();
    endtask

    task automatic async_reset_now();
        rst_n = 1'b0;
        m = reset_state();
        q.delete();
        push_expect();
    endtask

    function automatic in_t rnd_in(input in_t prev, input bit hold);
        in_t n;
        n = hold ? prev : nop();
        if (!hold) begin
            n.valid = ($urandom_range(0, 7) != 0);
            n.rs = 5'($urandom_range(0, 4)); n.rt = 5'($urandom_range(0, 4));
            n.rd = 5'($urandom_range(0, 4));
            n.rs_data = $urandom; n.rt_data = $urandom; n.imm = $urandom;
            n.alu_ctr = 4'($urandom_range(0, 15)); n.alu_src = 1'($urandom);
            n.rt_used = 1'($urandom);
            n.mr = ($urandom_range(0, 2) == 0);
            n.rw = n.mr | 1'($urandom);
            n.mw = !n.mr && ($urandom_range(0, 5) == 0);
        end
        n.flush = ($urandom_range(0, 11) == 0);
        n.xw = 1'($urandom); n.xrd = 5'($urandom_range(0, 4)); n.xres = $urandom;
        n.ww = 1'($urandom); n.wrd = 5'($urandom_range(0, 4)); n.wres = $urandom;
        return n;
    endfunction

    // Monitor: compares whatever the DUT presents mid-cycle with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", W'(ex_valid), W'(e.valid));
                chk("ex_reg_write", W'(ex_reg_write), W'(e.rw));
                chk("ex_mem_read", W'(ex_mem_read), W'(e.mr));
                chk("ex_mem_write", W'(ex_mem_write), W'(e.mw));
                chk("ALU_ctr", W'(ALU_ctr), W'(e.alu));
                chk("stall", W'(stall), W'(e.stall));
                if (e.chk) begin
                    chk("ex_rd", W'(ex_rd), W'(e.rd));
                    chk("data1", data1, e.d1);
                    chk("data2", data2, e.d2);
                    chk("ex_store_data", ex_store_data, e.sd);
                end
            end
        end
    end

    initial begin
        in_t n, a, lw, add;
        rst_n = 1'b0;
        cur = nop();
        drive(cur);
        m = reset_state();
        last_stall = 0;
        repeat (3) cyc(nop());
        #1;
        chk("rst_alu", W'(ALU_ctr), 15);
        chk("rst_valid", W'(ex_valid), 0);
        chk("rst_data1", data1, 0);
        rst_n = 1'b1;

        // Plain capture
        n = nop(); n.valid = 1; n.rs = 1; n.rs_data = 5; n.rt = 2; n.rt_data = 7;
        n.rt_used = 1; n.rd = 3; n.rw = 1; n.alu_ctr = 2;
        cyc(n);
        cyc(nop());
        #1;
        chk("cap_alu", W'(ALU_ctr), 2);
        chk("cap_data1", data1, 5);
        chk("cap_data2", data2, 7);
        chk("cap_valid", W'(ex_valid), 1);

        // Both later stages write r1: EX/MEM wins, then MEM/WB once EX/MEM moves away
        cyc(n);
        a = n; a.xw = 1; a.xrd = 1; a.xres = 100; a.ww = 1; a.wrd = 1; a.wres = 200;
        cyc(a);
        #1 chk("fwd_exmem", data1, 100);
        a.xrd = 3;
        cyc(a);
        #1 chk("fwd_memwb", data1, 200);

        // Load-use
        lw = nop(); lw.valid = 1; lw.rs = 2; lw.rd = 4; lw.mr = 1; lw.rw = 1; lw.alu_src = 1;
        add = nop(); add.valid = 1; add.rs = 4; add.rt = 5; add.rd = 6; add.rt_used = 1;
        add.rw = 1; add.alu_ctr = 2;
        cyc(lw);
        cyc(add);
        #1 chk("lu_stall", W'(stall), 1);
        cyc(add);
        #1;
        chk("lu_bubble_valid", W'(ex_valid), 0);
        chk("lu_bubble_alu", W'(ALU_ctr), 15);
        chk("lu_stall_gone", W'(stall), 0);
        cyc(nop());
        #1;
        chk("lu_add_valid", W'(ex_valid), 1);
        chk("lu_add_alu", W'(ALU_ctr), 2);

        // Immediate operand, r0 never forwarded
        n = nop(); n.valid = 1; n.alu_src = 1; n.imm = 32'hFFFF_FFFC; n.alu_ctr = 1;
        cyc(n);
        a = nop(); a.xw = 1; a.xrd = 0; a.xres = 9;
        cyc(a);
        #1;
        chk("imm_data2", data2, 32'hFFFF_FFFC);
        chk("r0_store", ex_store_data, 0);

        // Flush overrides a load-use stall
        cyc(lw);
        a = add; a.flush = 1;
        cyc(a);
        #1 chk("flush_stall", W'(stall), 0);
        cyc(add);
        #1 chk("flush_bubble", W'(ex_valid), 0);
        cyc(nop());
        #1 chk("pre_rst_valid", W'(ex_valid), 1);

        // Asynchronous reset between edges
        async_reset_now();
        #1;
        chk("arst_valid", W'(ex_valid), 0);
        chk("arst_alu", W'(ALU_ctr), 15);
        chk("arst_rw", W'(ex_reg_write), 0);
        chk("arst_rd", W'(ex_rd), 0);
        chk("arst_data1", data1, 0);
        chk("arst_data2", data2, 0);
        chk("arst_store", ex_store_data, 0);
        chk("arst_stall", W'(stall), 0);
        cyc(add);
        cyc(add);
        rst_n = 1'b1;

        // Random traffic; upstream re-presents the same instruction after a stall
        for (int i = 0; i < 3000; i++) begin
            cyc(rnd_in(cur, last_stall));
            if ($urandom_range(0, 399) == 0) begin
                #1 async_reset_now();
                cyc(rnd_in(cur, 0));
                rst_n = 1'b1;
            end
        end

        cyc(nop());
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
